uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial receiver that sits directly downstream of the UART transmitter and consumes its `tx` line: start bit, FRAME_WIDTH data bits LSB first, one stop bit, idle high.
- Synchronises the asynchronous serial input.
- Validates the start bit at mid-bit and samples every data bit at mid-bit.
- Checks the stop bit.
- Presents the received byte with a one-cycle done strobe, or a one-cycle framing-error strobe.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be even and >= 4; same value as the transmitter's baud counter.
- FRAME_WIDTH, 8, data bits per frame.
- CNT_WIDTH, 8, width of the bit-period counter; must satisfy 2^CNT_WIDTH > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- data  output  FRAME_WIDTH  last correctly received frame.
- done  output  1  one-cycle pulse when `data` is updated.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: on a clk edge with rst=1, all outputs and internal state clear.
  - data=0, done=0, frame_err=0, busy=0.
  - state=IDLE, counters=0, shift register=0.
  - Both synchroniser flops are set to 1 (idle level).
  - rst is honoured from any state mid-frame; the partial frame is discarded with no done or frame_err.
- Synchroniser: s1<=rx, s2<=s1. The FSM only ever observes s2.
- Counter cnt: counts 0..CLKS_PER_BIT-1. It is cleared on every state change and on every bit sample.
- bit_idx: counts 0..FRAME_WIDTH-1.
- States: IDLE, START, DATA, STOP, RECOVER.
- IDLE:
  - If s2==0: go to START, cnt<=0.
  - Otherwise stay in IDLE.
- START:
  - cnt increments each cycle.
  - When cnt==CLKS_PER_BIT/2-1 and s2==1: glitch; return to IDLE with no outputs.
  - When cnt==CLKS_PER_BIT/2-1 and s2==0: go to DATA, cnt<=0, bit_idx<=0.
- DATA:
  - When cnt==CLKS_PER_BIT-1: shift s2 into the MSB of the shift register (right shift, so the first bit lands at LSB after FRAME_WIDTH shifts), then increment bit_idx.
  - When the sample is taken with bit_idx==FRAME_WIDTH-1: go to STOP.
- STOP:
  - When cnt==CLKS_PER_BIT-1 and s2==1: data<=shift register, done<=1, go to IDLE.
  - When cnt==CLKS_PER_BIT-1 and s2==0: frame_err<=1, data unchanged, go to RECOVER.
- RECOVER:
  - Stay until s2==1, then go to IDLE.
  - Purpose: a held-low line (break) must never be re-detected as a start bit.
- done and frame_err are registered and high for exactly one cycle. They are never high together.
- Latency: let E0 be the clk edge at which s1 first captures rx=0. Then:
  - The START entry edge is E0+2.
  - The start bit is validated at E0+2+CLKS_PER_BIT/2.
  - Data bit k (k=1..FRAME_WIDTH) is sampled at E0+2+CLKS_PER_BIT/2+k*CLKS_PER_BIT.
  - done or frame_err is asserted after edge E0+2+CLKS_PER_BIT/2+(FRAME_WIDTH+1)*CLKS_PER_BIT. With defaults this is E0+154.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start bit that begins immediately after the nominal stop-bit end is received with no loss.
- busy rises on the edge that enters START. It falls on the edge that enters IDLE.
- data holds its value until the next good frame; there is no consumer handshake. A new frame overwrites the previous one.

Test Plan:
1. Nominal frame: reset, then drive the frame for 0xA5 at 16 clk/bit -> done pulse at E0+154, data=0xA5, frame_err=0, busy low one cycle after done.
2. Back-to-back: 0x00 then 0xFF with no idle gap -> two done pulses 160 cycles apart, data=0x00 then 0xFF.
3. Start glitch: drive rx low for 3 cycles, then high -> busy pulses then returns to 0, no done, no frame_err; a following 0x3C frame is received correctly.
4. Framing error: frame 0x5A with the stop bit held low, then rx low for 50 more cycles, then high, then a 0x81 frame -> frame_err pulse, data stays at its prior value, busy held through the low period, then done with data=0x81.
5. Reset mid-frame: assert rst during data bit 4 of a 0xC3 frame -> next cycle busy=0, data=0, no strobes; the next clean 0x69 frame gives data=0x69.
6. Loopback: connect to the team transmitter with matching CLKS_PER_BIT and send 0x00, 0x55, 0xAA, 0xFF -> four done pulses with matching data, zero frame_err.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: serial receiver for 8N1-style frames (start, FRAME_WIDTH data bits
// LSB first, one stop bit, idle high). Two-flop synchroniser on the line,
// mid-bit sampling, and one-cycle done / frame_err strobes.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FRAME_WIDTH  = 8,
    parameter int unsigned CNT_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    output logic [FRAME_WIDTH-1:0] data,
    output logic                   done,
    output logic                   frame_err,
    output logic                   busy
);

    localparam int unsigned IDX_WIDTH = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;

    // Counter terminal values: half a bit for start validation, a full bit otherwise.
    localparam logic [CNT_WIDTH-1:0] HALF_LAST = CNT_WIDTH'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [IDX_WIDTH-1:0] IDX_LAST  = IDX_WIDTH'(FRAME_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        RECOVER = 3'd4
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   cnt_nxt;
    logic [IDX_WIDTH-1:0]   bit_idx;
    logic [IDX_WIDTH-1:0]   bit_idx_nxt;
    logic [FRAME_WIDTH-1:0] shreg;
    logic [FRAME_WIDTH-1:0] shreg_nxt;
    logic [FRAME_WIDTH-1:0] data_nxt;
    logic                   done_nxt;
    logic                   frame_err_nxt;
    logic                   busy_nxt;
    logic                   s1;
    logic                   s2;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= rx;
            s2 <= s1;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shreg     <= shreg_nxt;
            data      <= data_nxt;
            done      <= done_nxt;
            frame_err <= frame_err_nxt;
            busy      <= busy_nxt;
        end
    end

    // Next-state and next-output logic; all sampling happens at counter terminal values.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt + CNT_WIDTH'(1);
        bit_idx_nxt   = bit_idx;
        shreg_nxt     = shreg;
        data_nxt      = data;
        done_nxt      = 1'b0;
        frame_err_nxt = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!s2) begin
                    state_nxt = START;
                end
            end

            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt = '0;
                    if (s2) begin
                        // Line went back high before mid-start: treat as a glitch.
                        state_nxt = IDLE;
                    end else begin
                        state_nxt   = DATA;
                        bit_idx_nxt = '0;
                    end
                end
            end

            DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_nxt   = '0;
                    // Right shift: the first (LSB) bit ends up at bit 0 after the last shift.
                    shreg_nxt = FRAME_WIDTH'({s2, shreg} >> 1);
                    if (bit_idx == IDX_LAST) begin
                        state_nxt   = STOP;
                        bit_idx_nxt = '0;
                    end else begin
                        bit_idx_nxt = bit_idx + IDX_WIDTH'(1);
                    end
                end
            end

            STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_nxt = '0;
                    if (s2) begin
                        data_nxt  = shreg;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = RECOVER;
                    end
                end
            end

            RECOVER: begin
                // Wait out a held-low line so a break is never seen as a new start bit.
                cnt_nxt = '0;
                if (s2) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. Each scenario task pushes the
// strobes it expects (kind, data, busy, cycle) and compares them with what the
// negedge monitor recorded.
module tb_uart_rx;

    localparam int unsigned CPB = 16;
    localparam int unsigned FW  = 8;
    localparam int unsigned LAT = 2 + CPB / 2 + (FW + 1) * CPB;

    typedef struct {
        logic          done;
        logic          err;
        logic [FW-1:0] data;
        logic          busy;
        int unsigned   cyc;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic [FW-1:0] data;
    logic          done;
    logic          frame_err;
    logic          busy;

    int unsigned cyc       = 0;
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    ev_t         exp_q[$];
    ev_t         obs_q[$];

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .FRAME_WIDTH (FW),
        .CNT_WIDTH   (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data     (data),
        .done     (done),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe, with the outputs seen alongside it.
    always @(negedge clk) begin
        if (done === 1'b1 || frame_err === 1'b1)
            obs_q.push_back('{done, frame_err, data, busy, cyc});
    end

    // Drive one frame starting at the current negedge; rx is left at the stop level.
    task automatic send_frame(input logic [FW-1:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < int'(FW); k++) begin
            rx = b[k];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic expect_done(input logic [FW-1:0] d, input int unsigned at);
        exp_q.push_back('{1'b1, 1'b0, d, 1'b0, at});
    endtask

    task automatic expect_err(input logic [FW-1:0] held, input int unsigned at);
        exp_q.push_back('{1'b0, 1'b1, held, 1'b1, at});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++; if (data !== 8'h00) $display("FAIL reset_data: got %h want 00", data); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
        total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", frame_err); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_nominal();
        ev_t e, o;
        expect_done(8'hA5, cyc + 1 + LAT);
        send_frame(8'hA5, 1'b1);
        for (int i = 0; i < 2000 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
        repeat (4) @(negedge clk);
        total_cnt++;
        if (obs_q.size() != exp_q.size()) $display("FAIL nominal_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total_cnt++;
            if ({o.done, o.err, o.data, o.busy} !== {e.done, e.err, e.data, e.busy} || o.cyc != e.cyc)
                $display("FAIL nominal_event: got done=%b err=%b data=%h busy=%b cyc=%0d want done=%b err=%b data=%h busy=%b cyc=%0d",
                         o.done, o.err, o.data, o.busy, o.cyc, e.done, e.err, e.data, e.busy, e.cyc);
            else pass_cnt++;
        end
        exp_q.delete(); obs_q.delete();
        total_cnt++; if (data !== 8'hA5) $display("FAIL nominal_hold: got %h want a5", data); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL nominal_idle_busy: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        ev_t e, o;
        expect_done(8'h00, cyc + 1 + LAT);
        expect_done(8'hFF, cyc + 1 + LAT + 10 * CPB);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        for (int i = 0; i < 2000 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
        repeat (4) @(negedge clk);
        total_cnt++;
        if (obs_q.size() != exp_q.size()) $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total_cnt++;
            if ({o.done, o.err, o.data, o.busy} !== {e.done, e.err, e.data, e.busy} || o.cyc != e.cyc)
                $display("FAIL b2b_event: got done=%b err=%b data=%h busy=%b cyc=%0d want done=%b err=%b data=%h busy=%b cyc=%0d",
                         o.done, o.err, o.data, o.busy, o.cyc, e.done, e.err, e.data, e.busy, e.cyc);
            else pass_cnt++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_glitch();
        ev_t e, o;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++; if (busy !== 1'b1) $display("FAIL glitch_busy_rise: got %b want 1", busy); else pass_cnt++;
        repeat (20) @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL glitch_busy_fall: got %b want 0", busy); else pass_cnt++;
        total_cnt++;
        if (obs_q.size() != 0) $display("FAIL glitch_strobe: got %0d strobes want 0", obs_q.size());
        else pass_cnt++;
        obs_q.delete();
        expect_done(8'h3C, cyc + 1 + LAT);
        send_frame(8'h3C, 1'b1);
        for (int i = 0; i < 2000 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
        repeat (4) @(negedge clk);
        total_cnt++;
        if (obs_q.size() != exp_q.size()) $display("FAIL glitch_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total_cnt++;
            if ({o.done, o.err, o.data, o.busy} !== {e.done, e.err, e.data, e.busy} || o.cyc != e.cyc)
                $display("FAIL glitch_event: got done=%b err=%b data=%h busy=%b cyc=%0d want done=%b err=%b data=%h busy=%b cyc=%0d",
                         o.done, o.err, o.data, o.busy, o.cyc, e.done, e.err, e.data, e.busy, e.cyc);
            else pass_cnt++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_framing();
        ev_t e, o;
        expect_err(8'h3C, cyc + 1 + LAT);
        send_frame(8'h5A, 1'b0);
        repeat (50) @(negedge clk);
        total_cnt++; if (busy !== 1'b1) $display("FAIL break_busy: got %b want 1", busy); else pass_cnt++;
        rx = 1'b1;
        repeat (5) @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL break_release: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (data !== 8'h3C) $display("FAIL break_data_hold: got %h want 3c", data); else pass_cnt++;
        expect_done(8'h81, cyc + 1 + LAT);
        send_frame(8'h81, 1'b1);
        for (int i = 0; i < 2000 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
        repeat (4) @(negedge clk);
        total_cnt++;
        if (obs_q.size() != exp_q.size()) $display("FAIL framing_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total_cnt++;
            if ({o.done, o.err, o.data, o.busy} !== {e.done, e.err, e.data, e.busy} || o.cyc != e.cyc)
                $display("FAIL framing_event: got done=%b err=%b data=%h busy=%b cyc=%0d want done=%b err=%b data=%h busy=%b cyc=%0d",
                         o.done, o.err, o.data, o.busy, o.cyc, e.done, e.err, e.data, e.busy, e.cyc);
            else pass_cnt++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        ev_t e, o;
        logic [FW-1:0] b;
        b  = 8'hC3;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            rx = b[k];
            repeat (CPB) @(negedge clk);
        end
        rx = b[4];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (data !== 8'h00) $display("FAIL midrst_data: got %h want 00", data); else pass_cnt++;
        total_cnt++; if ({done, frame_err} !== 2'b00) $display("FAIL midrst_strobes: got %b want 00", {done, frame_err}); else pass_cnt++;
        repeat (200) @(negedge clk);
        total_cnt++;
        if (obs_q.size() != 0) $display("FAIL midrst_quiet: got %0d strobes want 0", obs_q.size());
        else pass_cnt++;
        obs_q.delete();
        expect_done(8'h69, cyc + 1 + LAT);
        send_frame(8'h69, 1'b1);
        for (int i = 0; i < 2000 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
        repeat (4) @(negedge clk);
        total_cnt++;
        if (obs_q.size() != exp_q.size()) $display("FAIL midrst_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total_cnt++;
            if ({o.done, o.err, o.data, o.busy} !== {e.done, e.err, e.data, e.busy} || o.cyc != e.cyc)
                $display("FAIL midrst_event: got done=%b err=%b data=%h busy=%b cyc=%0d want done=%b err=%b data=%h busy=%b cyc=%0d",
                         o.done, o.err, o.data, o.busy, o.cyc, e.done, e.err, e.data, e.busy, e.cyc);
            else pass_cnt++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_loopback();
        ev_t e, o;
        logic [FW-1:0] pat [4];
        int unsigned   t0;
        pat[0] = 8'h00; pat[1] = 8'h55; pat[2] = 8'hAA; pat[3] = 8'hFF;
        t0 = cyc + 1 + LAT;
        for (int i = 0; i < 4; i++) expect_done(pat[i], t0 + 10 * CPB * i);
        for (int i = 0; i < 4; i++) send_frame(pat[i], 1'b1);
        for (int i = 0; i < 2000 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
        repeat (4) @(negedge clk);
        total_cnt++;
        if (obs_q.size() != exp_q.size()) $display("FAIL loop_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total_cnt++;
            if ({o.done, o.err, o.data, o.busy} !== {e.done, e.err, e.data, e.busy} || o.cyc != e.cyc)
                $display("FAIL loop_event: got done=%b err=%b data=%h busy=%b cyc=%0d want done=%b err=%b data=%h busy=%b cyc=%0d",
                         o.done, o.err, o.data, o.busy, o.cyc, e.done, e.err, e.data, e.busy, e.cyc);
            else pass_cnt++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_nominal();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_mid_frame();
        test_loopback();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
